// File: rtl/bcnt_arb.sv
// Round-robin owner of a single shared down-counting delay timer.
// One requester at a time gets the timer and sees a one-cycle done pulse when its count expires.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | timer free, arbitrating among pending requests
// S_RUN  | timer owned, counting down on tick, abort if owner drops req
// S_DONE | count expired, done pulse to owner, back to IDLE next edge

module bcnt_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               sclr_n,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] len,
    input  logic               tick,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic               busy,
    output logic [WIDTH-1:0]   q
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    last_q;
    logic [WIDTH-1:0] cnt_q;
    logic [N-1:0]     gnt_q;
    logic [N-1:0]     done_q;

    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [N-1:0]     win_oh;
    logic [WIDTH-1:0] len_a [N];

    for (genvar g = 0; g < N; g++) begin : g_len
        assign len_a[g] = len[g*WIDTH +: WIDTH];
    end

    // Channels above the last grant rank first; the second pass wraps to 0..last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_vld && req[i] && (IW'(i) > last_q)) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!win_vld && req[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        state_q <= S_RUN;
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                        cnt_q   <= len_a[win_idx];
                        gnt_q   <= win_oh;
                    end
                end
                S_RUN: begin
                    if (!req[owner_q]) begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        // zero count completes without waiting for a tick
                        state_q <= S_DONE;
                        done_q  <= gnt_q;
                    end else if (tick) begin
                        cnt_q <= cnt_q - WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);
    assign q    = cnt_q;

endmodule

// File: tb/tb_bcnt_arb.sv
// Self-checking bench for bcnt_arb (N=4, WIDTH=4): vector table, directed corner cases,
// and randomized traffic compared every cycle against a channel-level reference model.

module tb_bcnt_arb;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           sclr_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic           tick;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   q;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: who owns the timer, what is left, and whether this is the done cycle
    int         m_owner = -1;
    int         m_last  = N - 1;
    logic [W-1:0] m_q   = '0;
    bit         m_dph   = 1'b0;

    bcnt_arb #(.N(N), .WIDTH(W)) dut (
        .clk    (clk),
        .sclr_n (sclr_n),
        .req    (req),
        .len    (len),
        .tick   (tick),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .q      (q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_len(input int ch, input logic [W-1:0] v);
        len[ch*W +: W] = v;
    endtask

    task automatic model_step();
        bit found;
        int c;
        if (!sclr_n) begin
            m_owner = -1;
            m_last  = N - 1;
            m_q     = '0;
            m_dph   = 1'b0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_q     = len[c*W +: W];
                end
            end
        end else if (m_dph) begin
            m_dph   = 1'b0;
            m_owner = -1;
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (m_q == 0) begin
            m_dph = 1'b1;
        end else if (tick) begin
            m_q = m_q - 1;
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return {g, (m_dph ? g : 4'b0000), (m_owner >= 0), m_q};
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 15;
    endfunction

    // one clock: model advances on the same edge, outputs compared 1 unit later
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model", {gnt, done, busy, q}, model_out());
    endtask

    task automatic do_reset();
        sclr_n = 1'b0;
        req    = '0;
        cycle();
        sclr_n = 1'b1;
    endtask

    typedef struct {
        logic       sclr;
        logic [3:0] req;
        logic [3:0] l0;
        logic       tick;
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic [3:0] q;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int            found;
        int            t3;
        int            dcyc;
        int            ticks;
        int            dcount;
        logic [3:0]    prev_q;
        logic          prev_run;
        logic [3:0]    prev_gnt;
        int            order[$];
        logic [15:0]   ord_p;

        sclr_n = 1'b0;
        req    = '0;
        len    = '0;
        tick   = 1'b1;

        // reset, then channel 0 with len 5 and tick held high; then a len 0 request
        tbl[0]  = '{1'b0, 4'b0000, 4'd5, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 4'b0001, 4'd5, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd5};
        tbl[2]  = '{1'b1, 4'b0001, 4'd5, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd4};
        tbl[3]  = '{1'b1, 4'b0001, 4'd5, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd3};
        tbl[4]  = '{1'b1, 4'b0001, 4'd5, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd2};
        tbl[5]  = '{1'b1, 4'b0001, 4'd5, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd1};
        tbl[6]  = '{1'b1, 4'b0001, 4'd5, 1'b1, 4'b0001, 4'b0000, 1'b1, 4'd0};
        tbl[7]  = '{1'b1, 4'b0001, 4'd5, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'd0};
        tbl[8]  = '{1'b1, 4'b0000, 4'd5, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 4'b0000, 4'd5, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0};
        tbl[10] = '{1'b1, 4'b0001, 4'd0, 1'b0, 4'b0001, 4'b0000, 1'b1, 4'd0};
        tbl[11] = '{1'b1, 4'b0001, 4'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 4'd0};
        tbl[12] = '{1'b1, 4'b0000, 4'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0};

        for (int i = 0; i < 13; i++) begin
            sclr_n = tbl[i].sclr;
            req    = tbl[i].req;
            set_len(0, tbl[i].l0);
            tick   = tbl[i].tick;
            cycle();
            chk($sformatf("tbl_row%0d", i), {gnt, done, busy, q},
                {tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].q});
        end

        // round robin: all request with len 0, each drops after its done
        do_reset();
        len  = '0;
        tick = 1'b1;
        req  = 4'b1111;
        prev_gnt = '0;
        order.delete();
        for (int c = 0; c < 60 && !(req == 0 && !busy); c++) begin
            cycle();
            if (gnt != 0 && prev_gnt == 0) order.push_back(oh_idx(gnt));
            if (done != 0) req = req & ~done;
            prev_gnt = gnt;
        end
        ord_p = 16'hFFFF;
        for (int i = 0; i < 4 && i < order.size(); i++) ord_p[i*4 +: 4] = 4'(order[i]);
        chk("rr_order_0123", ord_p, 16'h3210);
        chk("rr_count", order.size(), 4);

        req = 4'b1001;
        prev_gnt = '0;
        order.delete();
        for (int c = 0; c < 40 && !(req == 0 && !busy); c++) begin
            cycle();
            if (gnt != 0 && prev_gnt == 0) order.push_back(oh_idx(gnt));
            if (done != 0) req = req & ~done;
            prev_gnt = gnt;
        end
        ord_p = 16'hFFFF;
        for (int i = 0; i < 2 && i < order.size(); i++) ord_p[i*4 +: 4] = 4'(order[i]);
        chk("rr_order_03", ord_p[7:0], 8'h30);
        chk("rr_count2", order.size(), 2);

        // tick gating: len 3 on channel 2, tick every 4th cycle
        do_reset();
        set_len(2, 4'd3);
        req   = 4'b0100;
        ticks = 0;
        t3    = -1;
        dcyc  = -1;
        for (int n = 0; n < 40 && dcyc < 0; n++) begin
            tick = ((n % 4) == 3);
            if (tick && m_owner >= 0 && !m_dph && m_q != 0) begin
                ticks++;
                if (ticks == 3) t3 = n;
            end
            prev_q   = q;
            prev_run = busy && (done == 0);
            cycle();
            if (!tick && prev_run) chk("tick_hold", q, prev_q);
            if (done == 4'b0100) dcyc = n + 1;
        end
        chk("tick_done_seen", (dcyc >= 0 && t3 >= 0), 1);
        chk("tick_done_lat", dcyc - t3, 2);
        req = '0;
        cycle();

        // abort: channel 1 len 10 dropped at q=6, channel 2 pending
        do_reset();
        tick = 1'b1;
        set_len(1, 4'd10);
        set_len(2, 4'd7);
        req   = 4'b0110;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            cycle();
            if (gnt == 4'b0010 && q == 4'd6) found = 1;
        end
        chk("abort_reach_q6", found, 1);
        req = 4'b0100;
        cycle();
        chk("abort_release", {gnt, done, busy}, {4'b0000, 4'b0000, 1'b0});
        cycle();
        chk("abort_regrant", {gnt, q}, {4'b0100, 4'd7});

        // reset mid-run: channel 0 owns, reset at q=4, channel 0 regains priority
        do_reset();
        tick = 1'b1;
        set_len(0, 4'd10);
        set_len(1, 4'd2);
        req   = 4'b0001;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            cycle();
            if (gnt == 4'b0001 && q == 4'd4) found = 1;
        end
        chk("rst_reach_q4", found, 1);
        sclr_n = 1'b0;
        req    = 4'b0011;
        cycle();
        chk("rst_mid_outputs", {gnt, done, busy, q}, 13'd0);
        sclr_n = 1'b1;
        cycle();
        chk("rst_regrant_ch0", {gnt, q}, {4'b0001, 4'd10});
        req = '0;
        cycle();

        // boundary: full-scale count 15 down to 0, no wrap, one done
        do_reset();
        tick = 1'b1;
        set_len(3, 4'd15);
        req = 4'b1000;
        cycle();
        chk("bnd_load", {gnt, q}, {4'b1000, 4'd15});
        for (int k = 1; k <= 15; k++) begin
            cycle();
            chk("bnd_q", q, 32'(15 - k));
        end
        cycle();
        chk("bnd_done", {gnt, done, q}, {4'b1000, 4'b1000, 4'd0});
        req = '0;
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (done != 0) dcount++;
            chk("bnd_nowrap", {busy, q}, {1'b0, 4'd0});
        end
        chk("bnd_no_extra_done", dcount, 0);

        // randomized traffic against the model
        do_reset();
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            sclr_n = ($urandom_range(0, 149) != 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
                set_len(b, W'($urandom_range(0, 15)));
            end
            tick = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bcnt_arb.md
# bcnt_arb

Round-robin scheduler that shares a single down-counting delay timer among `N` requesters. Each requester presents a tick count and holds a request. The block grants the timer to one requester at a time, loads its count, and counts down on an external tick strobe. When the count is exhausted it returns a one-cycle `done` pulse to the owner. It sits between software-visible timeout or delay channels and the timing datapath, replacing `N` dedicated binary counters.

## Interface
Parameters:
- `N`, 4, number of requesting channels (2..16)
- `WIDTH`, 16, width of each requested count and of the shared counter

Ports:
- `clk`  in  1  clock
- `sclr_n`  in  1  synchronous reset, active-low
- `req`  in  `N`  per-channel request level; holding high means "wants or keeps the timer"
- `len`  in  `N*WIDTH`  per-channel tick count; channel `i` uses bits `[i*WIDTH +: WIDTH]`, sampled only at grant
- `tick`  in  1  count-enable strobe (prescaler output); may be constant 1
- `gnt`  out  `N`  one-hot owner of the timer; all zeros when free
- `done`  out  `N`  one-hot, one-cycle pulse; the owner's count has expired
- `busy`  out  1  timer owned (RUN or DONE state)
- `q`  out  `WIDTH`  current remaining count

## Operation
- The clock is `clk`, a single domain. `sclr_n` is sampled on the rising edge, and low has priority over all other inputs.
- Reset values:
  - state is IDLE
  - `gnt`, `done`, `busy` and `q` are 0
  - the internal owner index is 0
  - the last-granted pointer is `N-1`, so channel 0 has first priority after reset
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - If any `req` bit is high, select the first high bit searching from `(last+1) mod N` upward, with wrap-around.
  - On the edge: load `q <= len[winner]`, set owner and last to the winner, and go to RUN.
  - With no request, stay in IDLE and hold `q`.
- RUN:
  - `gnt[owner]` and `busy` are 1.
  - Priority order within RUN:
    1. If `req[owner]` is 0, abort: go to IDLE with no `done` and `q` unchanged. The pointer has already advanced to the owner.
    2. Else if `q` is 0, go to DONE. No tick is needed, so a request with `len` = 0 completes with zero ticks.
    3. Else if `tick` is 1, `q <= q - 1`.
    4. Otherwise hold.
- DONE:
  - `done[owner]` is 1 for exactly this cycle, and `gnt[owner]` stays 1.
  - Unconditionally go to IDLE, even if `req[owner]` drops in this cycle.
- A requester must drop `req` after `done`. If it holds `req`, it is re-eligible but ranks last under round-robin.
- `len` changes made while a channel is owned have no effect. The value is sampled only at the IDLE→RUN edge.
- `q` arithmetic is `WIDTH`-bit unsigned. `q` never decrements below 0 and never wraps.
- Requests from non-owners during RUN or DONE are ignored and not queued. They are seen again in IDLE.

## Timing
- Grant latency: `req` high in IDLE on cycle 0 → `gnt` and `busy` high and `q = len` on cycle 1.
- With `tick` constant 1 and `len = L`:
  - `q` reaches 0 on cycle `1+L`
  - `done` is high on cycle `2+L`
  - the state is IDLE on cycle `3+L`
  - the next grant is on cycle `4+L`
- Each low `tick` cycle in RUN adds one cycle of latency.
- Minimum ownership is 2 cycles (`len` = 0): RUN, then DONE.
- Abort takes effect on the edge after `req[owner]` falls. `gnt` is low one cycle after the drop, and a new grant can follow one cycle later.
- `sclr_n` low in any state: on the next edge all outputs return to reset values. A pending `done` is lost, and no `done` is ever issued for a grant interrupted by reset.
- `gnt` and `done` are registered. `busy` is registered or decoded from the state register, with no combinational path from inputs.

## Test plan
- Reset then single request:
  - Stimulus: `req` = 0001, `len0` = 5, `tick` = 1.
  - Response: `gnt` = 0001 on cycle 1, `q` steps 5→0, `done` = 0001 on cycle 7 for exactly one cycle, `busy` low on cycle 8.
- Round-robin fairness:
  - Stimulus: `req` = 1111 held, all `len` = 0, each requester drops `req` one cycle after its `done`.
  - Response: grant order is 0,1,2,3. Then re-raise `req` = 1001: order is 0, then 3.
- Tick gating:
  - Stimulus: `len2` = 3, `tick` high every 4th cycle.
  - Response: `done` = 0100 exactly 2 cycles after the 3rd tick, and `q` holds between ticks.
- Abort:
  - Stimulus: channel 1 granted with `len` = 10, `req[1]` dropped while `q` = 6.
  - Response: no `done`, `gnt` = 0 next cycle, and a pending `req[2]` is granted one cycle later.
- Reset mid-run:
  - Stimulus: `sclr_n` low for 1 cycle while `q` = 4.
  - Response: `gnt`, `done`, `busy` and `q` are all 0. The next grant goes to channel 0 if `req[0]` is high, despite the prior owner.
- Boundary:
  - Stimulus: `WIDTH` = 4, `len` = 15.
  - Response: `q` counts 15→0 with no wrap, and `done` fires once.
